// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM states, frame width and line levels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // Transmitter frame phases
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // Payload bits per frame (8N1)
    localparam int UART_DATA_BITS = 8;

    // Serial line levels for the framing bits; idle also uses the stop level
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the last count.
// Latency: bit_done asserts CLKS_PER_BIT-1 cycles after clear while enabled.
// Backpressure: none; free-running while en is high, restarted by clr.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_done
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Count cycles within the current bit, wrapping at the last cycle of the bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign bit_done = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_core.sv
// UART 8N1 transmitter: serialises one byte per valid/ready handshake, LSB first, idle-high line.
// Latency: start bit on the line from the acceptance edge; o_ready returns 10*CLKS_PER_BIT cycles later.
// Backpressure: o_ready low for the whole frame; i_valid/i_data ignored until back in IDLE.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_uart_tx
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    uart_state_t          state, state_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic [2:0]           bit_idx, bit_idx_nxt;
    logic                 tx_q, tx_nxt;
    logic                 accept;
    logic                 bit_done;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (i_clk),
        .rst      (i_rst),
        .clr      (accept),
        .en       (state != ST_IDLE),
        .bit_done (bit_done)
    );

    // State, shift register, bit index and registered line output
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            shift   <= '0;
            bit_idx <= '0;
            tx_q    <= STOP_BIT;
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            bit_idx <= bit_idx_nxt;
            tx_q    <= tx_nxt;
        end
    end

    // Next-state logic; the line value for the next bit is computed here so it
    // lands in tx_q on the same edge the state changes
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_idx_nxt = bit_idx;
        tx_nxt      = tx_q;
        accept      = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_nxt = STOP_BIT;
                if (i_valid) begin
                    accept      = 1'b1;
                    shift_nxt   = i_data;
                    bit_idx_nxt = '0;
                    tx_nxt      = START_BIT;
                    state_nxt   = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    tx_nxt    = shift[0];
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_nxt = shift >> 1;
                    if (bit_idx == LAST_IDX) begin
                        tx_nxt    = STOP_BIT;
                        state_nxt = ST_STOP;
                    end else begin
                        tx_nxt      = shift[1];
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tx_nxt    = STOP_BIT;
            end
        endcase
    end

    assign o_ready   = (state == ST_IDLE);
    assign o_uart_tx = tx_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: CLKS_PER_BIT=4 main instance plus a CLKS_PER_BIT=2 boundary instance.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_uart_tx_core;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       v1, v2;
    logic       rdy1, rdy2;
    logic       tx1, tx2;

    int n_cmp;
    int n_err;

    // Falling-edge monitor on the main line, used for start-to-start spacing
    int cyc;
    int last_fall;
    int prev_fall;
    logic prev_tx1;

    uart_tx_core #(.CLKS_PER_BIT(4)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_data    (data),
        .i_valid   (v1),
        .o_ready   (rdy1),
        .o_uart_tx (tx1)
    );

    uart_tx_core #(.CLKS_PER_BIT(2)) dut2 (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_data    (data),
        .i_valid   (v2),
        .o_ready   (rdy2),
        .o_uart_tx (tx2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Track 1->0 transitions of the main line at each sampling point
    initial begin
        cyc = 0; last_fall = -1; prev_fall = -1; prev_tx1 = 1'b1;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (prev_tx1 && !tx1) begin
                prev_fall = last_fall;
                last_fall = cyc;
            end
            prev_tx1 = tx1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sample one whole frame starting at the first negedge after acceptance.
    // bits[i] is the i-th transmitted bit; hold_ok clears if any bit wobbles.
    // At sample chg_idx the inputs are overwritten with chg_data/chg_valid.
    task automatic capture(input bit sel, input int n, input int chg_idx,
                           input logic [7:0] chg_data, input logic chg_valid,
                           output logic [9:0] bits, output int hold_ok, output int rdy_low);
        logic line;
        bits = '0; hold_ok = 1; rdy_low = 0;
        for (int c = 0; c < 10 * n; c++) begin
            @(negedge clk);
            line = sel ? tx2 : tx1;
            if (c % n == 0) bits[c / n] = line;
            else if (line !== bits[c / n]) hold_ok = 0;
            if ((sel ? rdy2 : rdy1) == 1'b0) rdy_low++;
            if (c == chg_idx) begin
                data = chg_data;
                if (sel) v2 = chg_valid; else v1 = chg_valid;
            end
        end
    endtask

    logic [9:0] bits;
    int         hold, rlow;

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b0; data = 8'h00; v1 = 1'b0; v2 = 1'b0;

        // Asynchronous reset between edges: outputs settle without a clock
        #2 rst = 1'b1;
        #1;
        chk("rst_imm_tx", {31'd0, tx1}, 32'd1);
        chk("rst_imm_rdy", {31'd0, rdy1}, 32'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rel_tx", {31'd0, tx1}, 32'd1);
        chk("rst_rel_rdy", {31'd0, rdy1}, 32'd1);

        // Single byte 0xA5, one-cycle valid
        data = 8'hA5; v1 = 1'b1;
        capture(1'b0, 4, 0, 8'hA5, 1'b0, bits, hold, rlow);
        chk("a5_bits", {22'd0, bits}, {22'd0, 10'b1_10100101_0});
        chk("a5_hold", hold, 32'd1);
        chk("a5_rdy_low", rlow, 32'd40);
        @(negedge clk);
        chk("a5_rdy_after", {31'd0, rdy1}, 32'd1);
        chk("a5_idle_tx", {31'd0, tx1}, 32'd1);
        repeat (2) @(negedge clk);

        // 0x3C with data change and valid drop during data bit 2 (samples 12..15)
        data = 8'h3C; v1 = 1'b1;
        capture(1'b0, 4, 13, 8'hFF, 1'b0, bits, hold, rlow);
        chk("chg_bits", {22'd0, bits}, {22'd0, 10'b1_00111100_0});
        chk("chg_hold", hold, 32'd1);
        repeat (3) @(negedge clk);
        chk("chg_no_retx", {31'd0, tx1}, 32'd1);

        // Back-to-back: 0x00 then 0xFF with valid held high
        data = 8'h00; v1 = 1'b1;
        capture(1'b0, 4, 5, 8'hFF, 1'b1, bits, hold, rlow);
        chk("b2b_f1_bits", {22'd0, bits}, {22'd0, 10'b1_00000000_0});
        @(negedge clk);
        chk("b2b_gap_tx", {31'd0, tx1}, 32'd1);
        chk("b2b_gap_rdy", {31'd0, rdy1}, 32'd1);
        capture(1'b0, 4, 0, 8'hFF, 1'b0, bits, hold, rlow);
        chk("b2b_f2_bits", {22'd0, bits}, {22'd0, 10'b1_11111111_0});
        chk("b2b_period", last_fall - prev_fall, 32'd41);
        repeat (2) @(negedge clk);

        // Reset during data bit 4 of 0x00 (samples 20..23)
        data = 8'h00; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        repeat (21) @(negedge clk);
        chk("mid_pre_tx", {31'd0, tx1}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx", {31'd0, tx1}, 32'd1);
        chk("mid_rst_rdy", {31'd0, rdy1}, 32'd1);
        // Valid while reset is held must not start a frame
        v1 = 1'b1;
        repeat (2) @(negedge clk);
        v1 = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_no_accept_tx", {31'd0, tx1}, 32'd1);
        data = 8'h55; v1 = 1'b1;
        capture(1'b0, 4, 0, 8'h55, 1'b0, bits, hold, rlow);
        chk("mid_55_bits", {22'd0, bits}, {22'd0, 10'b1_01010101_0});
        chk("mid_55_hold", hold, 32'd1);
        repeat (2) @(negedge clk);

        // Boundary: CLKS_PER_BIT=2, 0x80 so the only 1 data bit is the last one
        data = 8'h80; v2 = 1'b1;
        capture(1'b1, 2, 0, 8'h80, 1'b0, bits, hold, rlow);
        chk("n2_bits", {22'd0, bits}, {22'd0, 10'b1_10000000_0});
        chk("n2_hold", hold, 32'd1);
        chk("n2_rdy_low", rlow, 32'd20);
        @(negedge clk);
        chk("n2_rdy_after", {31'd0, rdy2}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
